// File: rtl/shift_reg_burst_engine.sv
// Universal shift register with rotate/arithmetic modes and a counted burst FSM.
// Operates as a SIPO/PISO engine between a parallel datapath and serial links.
module shift_reg_burst_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] p_din,
   input  logic             s_left_din,
   input  logic             s_right_din,
   input  logic             start,
   input  logic             burst_dir,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] p_dout,
   output logic             s_left_dout,
   output logic             s_right_dout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic {IDLE, BURST} state_e;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SHR  = 3'b001,
      OP_SHL  = 3'b010,
      OP_LOAD = 3'b011,
      OP_ROR  = 3'b100,
      OP_ROL  = 3'b101,
      OP_ASR  = 3'b110,
      OP_RSVD = 3'b111
   } op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] shift_r, shift_l;

   assign shift_r = {s_right_din, data_q[WIDTH-1:1]};
   assign shift_l = {data_q[WIDTH-2:0], s_left_din};

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // A zero-length burst completes immediately without leaving IDLE.
               if (burst_len != '0) begin
                  dir_d   = burst_dir;
                  cnt_d   = burst_len;
                  state_d = BURST;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               case (op_e'(mode))
                  OP_SHR:  data_d = shift_r;
                  OP_SHL:  data_d = shift_l;
                  OP_LOAD: data_d = p_din;
                  OP_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                  OP_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                  OP_ASR:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                  default: data_d = data_q;
               endcase
            end
         end
         BURST: begin
            data_d = dir_q ? shift_l : shift_r;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   assign p_dout       = data_q;
   assign s_left_dout  = data_q[WIDTH-1];
   assign s_right_dout = data_q[0];
   assign busy         = (state_q == BURST);
   assign done         = done_q;
   assign remaining    = cnt_q;

endmodule
